// File: rtl/dmem_dma_if.sv
// Data-memory port bundle between the copy engine (master) and the
// single-port word memory (slave).
//   we : write enable, write commits on the rising clock edge
//   a  : byte address, [1:0] always 0 from the master
//   wd : write data
//   rd : registered read data, valid the cycle after the address
interface dmem_dma_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, a, wd, input rd);
  modport slave  (input we, a, wd, output rd);
endinterface

// File: rtl/dmem_dma.sv
// Block-copy DMA: copies len 32-bit words from src_addr to dst_addr over the
// data-memory port, one RD cycle then one WR cycle per word.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              transfer request, only looked at in IDLE
//   src_addr, dst_addr byte addresses, [1:0] ignored
//   len                word count (0 completes immediately, no accesses)
//   busy               high in RD/WR
//   done               one-cycle pulse after the last write
//   mem                memory port (master side)
module dmem_dma #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  dmem_dma_if.master       mem
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t           state, nxt;
  // Pointers hold word addresses only; the 30-bit add wraps modulo 2^32 bytes.
  logic [29:0]      src_ptr, dst_ptr;
  logic [LEN_W-1:0] remaining;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
    end else begin
      state <= nxt;
      unique case (state)
        IDLE: if (start) begin
          src_ptr   <= src_addr[31:2];
          dst_ptr   <= dst_addr[31:2];
          remaining <= len;
        end
        RD:   src_ptr <= src_ptr + 30'd1;
        WR: begin
          dst_ptr   <= dst_ptr + 30'd1;
          remaining <= remaining - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs decode from state only, so reset forces them all to 0 at once.
  always_comb begin
    nxt    = state;
    busy   = 1'b0;
    done   = 1'b0;
    mem.we = 1'b0;
    mem.a  = '0;
    mem.wd = '0;
    unique case (state)
      IDLE: if (start) nxt = (len == '0) ? DONE : RD;
      RD: begin
        busy  = 1'b1;
        mem.a = {src_ptr, 2'b00};
        nxt   = WR;
      end
      WR: begin
        busy   = 1'b1;
        mem.we = 1'b1;
        mem.a  = {dst_ptr, 2'b00};
        // Memory's read register is the only pipeline stage: forward straight through.
        mem.wd = mem.rd;
        nxt    = (remaining == LEN_W'(1)) ? DONE : RD;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_dma.sv
module tb_dmem_dma;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [7:0]  len = '0;
  logic        busy, done;

  dmem_dma_if mem ();

  dmem_dma #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr),
    .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .mem(mem)
  );

  always #5 clk = ~clk;

  // Sparse word memory, registered read, synchronous write.
  logic [31:0] ram   [bit [29:0]];
  logic [31:0] ref_m [bit [29:0]];
  logic [31:0] rd_t;

  function automatic logic [31:0] rget(bit [29:0] k);
    return ram.exists(k) ? ram[k] : 32'h0;
  endfunction
  function automatic logic [31:0] mget(bit [29:0] k);
    return ref_m.exists(k) ? ref_m[k] : 32'h0;
  endfunction

  always @(posedge clk) begin
    rd_t = rget(mem.a[31:2]);
    if (mem.we) ram[mem.a[31:2]] = mem.wd;
    mem.rd <= rd_t;
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // Reference: forward word-by-word copy on a snapshot of memory, wrapping
  // the word index at 2^30. Overlap replication falls out naturally.
  logic [31:0] exp_tr[$];
  task automatic model_copy(input logic [31:0] s, input logic [31:0] d, input int n);
    bit [29:0] ws, wdx;
    ref_m = ram;
    exp_tr.delete();
    for (int i = 0; i < n; i++) begin
      ws  = s[31:2] + 30'(i);
      wdx = d[31:2] + 30'(i);
      ref_m[wdx] = mget(ws);
      exp_tr.push_back({ws, 2'b00});
      exp_tr.push_back({wdx, 2'b00});
    end
  endtask

  task automatic check_mem(input string nm);
    int bad = 0;
    foreach (ref_m[k]) if (rget(k) !== ref_m[k]) bad++;
    foreach (ram[k])   if (ram[k] !== mget(k)) bad++;
    chk(nm, 64'(bad), 64'd0);
  endtask

  // Per-transfer observations.
  int r_done_cnt, r_done_cyc, r_busy_cnt, r_busy_first, r_busy_last, r_we_cnt, r_stray;
  logic [31:0] r_tr[$];

  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n,
                          input int poke1, input int poke2, input int rst_cyc);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(posedge clk);  // cycle 0 edge
    r_done_cnt = 0; r_done_cyc = 0; r_busy_cnt = 0; r_busy_first = 0;
    r_busy_last = 0; r_we_cnt = 0; r_stray = 0; r_tr.delete();
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == poke1 || c == poke2) begin
        start = 1'b1; src_addr = $urandom; dst_addr = $urandom; len = 8'($urandom_range(1, 9));
      end
      if (rst_cyc != 0 && c == rst_cyc + 1) rst_n = 1'b1;
      if (busy) begin
        r_busy_cnt++;
        if (r_busy_first == 0) r_busy_first = c;
        r_busy_last = c;
        r_tr.push_back(mem.a);
      end
      if (done) begin r_done_cnt++; if (r_done_cyc == 0) r_done_cyc = c; end
      if (mem.we) r_we_cnt++;
      if (!busy && (mem.we || mem.a != 0 || mem.wd != 0)) r_stray++;
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_we",   64'(mem.we), 64'd0);
        chk("rst_a",    64'(mem.a), 64'd0);
        chk("rst_wd",   64'(mem.wd), 64'd0);
      end
      if (rst_cyc != 0 && c >= rst_cyc + 5) break;
      if (rst_cyc == 0 && r_done_cyc != 0 && c >= r_done_cyc + 3) break;
    end
  endtask

  task automatic verify(input string nm, input int n, input int e_done, input int e_busy, input int e_we);
    int bad = 0;
    chk({nm, "_done_cnt"}, 64'(r_done_cnt), 64'd1);
    chk({nm, "_done_cyc"}, 64'(r_done_cyc), 64'(e_done));
    chk({nm, "_busy_cnt"}, 64'(r_busy_cnt), 64'(e_busy));
    chk({nm, "_busy_span"}, 64'(r_busy_last - r_busy_first + ((n > 0) ? 1 : 0)), 64'(e_busy));
    chk({nm, "_we_cnt"}, 64'(r_we_cnt), 64'(e_we));
    chk({nm, "_stray"}, 64'(r_stray), 64'd0);
    if (r_tr.size() != exp_tr.size()) bad++;
    else foreach (exp_tr[i]) if (r_tr[i] !== exp_tr[i]) bad++;
    chk({nm, "_trace"}, 64'(bad), 64'd0);
    check_mem({nm, "_mem"});
  endtask

  typedef struct {
    logic [31:0] src, dst;
    logic [7:0]  len;
    int          e_done, e_busy, e_we;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [31:0] s, d;
    int n;
    vt.push_back('{32'h0000_0000, 32'h0000_0040, 8'd4,   9,   8,   4});
    vt.push_back('{32'h0000_0010, 32'h0000_0200, 8'd0,   1,   0,   0});
    vt.push_back('{32'h0000_0020, 32'h0000_0300, 8'd1,   3,   2,   1});
    vt.push_back('{32'h0000_0080, 32'h0000_0080, 8'd5,  11,  10,   5});
    vt.push_back('{32'h0000_0043, 32'h0000_0100, 8'd3,   7,   6,   3});
    vt.push_back('{32'h0000_0000, 32'h0000_0800, 8'd255, 511, 510, 255});

    // Reset state
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_we",   64'(mem.we), 64'd0);
    chk("reset_a",    64'(mem.a), 64'd0);
    chk("reset_wd",   64'(mem.wd), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Basic copy with known words
    ram[0] = 32'h1111_1111; ram[1] = 32'h2222_2222; ram[2] = 32'h3333_3333; ram[3] = 32'h4444_4444;
    model_copy(32'h0, 32'h40, 4);
    run_xfer(32'h0, 32'h40, 8'd4, 0, 0, 0);
    verify("basic", 4, 9, 8, 4);
    chk("basic_w16", 64'(rget(30'd16)), 64'h1111_1111);
    chk("basic_w19", 64'(rget(30'd19)), 64'h4444_4444);

    // Table-driven vectors over randomized memory contents
    for (int i = 0; i < 1024; i++) ram[30'(i)] = $urandom;
    foreach (vt[i]) begin
      model_copy(vt[i].src, vt[i].dst, int'(vt[i].len));
      run_xfer(vt[i].src, vt[i].dst, vt[i].len, 0, 0, 0);
      verify($sformatf("vec%0d", i), int'(vt[i].len), vt[i].e_done, vt[i].e_busy, vt[i].e_we);
    end

    // Start while busy: pokes in WR (cycle 2) and DONE (cycle 7) are ignored
    model_copy(32'h100, 32'h200, 3);
    run_xfer(32'h100, 32'h200, 8'd3, 2, 7, 0);
    verify("startbusy", 3, 7, 6, 3);

    // Reset in cycle 4: only destination word 0 committed, no done
    ram[30'h0C0] = 32'hA0A0_0001; ram[30'h0C1] = 32'hA0A0_0002;
    ram[30'h100] = 32'hDEAD_0000; ram[30'h101] = 32'hDEAD_0001;
    run_xfer(32'h300, 32'h400, 8'd4, 0, 0, 4);
    chk("rstmid_done", 64'(r_done_cnt), 64'd0);
    chk("rstmid_w0", 64'(rget(30'h100)), 64'hA0A0_0001);
    chk("rstmid_w1", 64'(rget(30'h101)), 64'hDEAD_0001);
    model_copy(32'h300, 32'h500, 1);
    run_xfer(32'h300, 32'h500, 8'd1, 0, 0, 0);
    verify("after_rst", 1, 3, 2, 1);

    // Address wrap with unaligned inputs
    ram[30'h3FFF_FFFF] = 32'hCAFE_0001; ram[30'h0] = 32'hCAFE_0002;
    model_copy(32'hFFFF_FFFE, 32'h0000_0081, 2);
    run_xfer(32'hFFFF_FFFE, 32'h0000_0081, 8'd2, 0, 0, 0);
    verify("wrap", 2, 5, 4, 2);
    chk("wrap_a0", 64'((r_tr.size() > 0) ? r_tr[0] : 32'h1), 64'hFFFF_FFFC);
    chk("wrap_a1", 64'((r_tr.size() > 1) ? r_tr[1] : 32'h1), 64'h0000_0080);
    chk("wrap_a2", 64'((r_tr.size() > 2) ? r_tr[2] : 32'h1), 64'h0000_0000);
    chk("wrap_a3", 64'((r_tr.size() > 3) ? r_tr[3] : 32'h1), 64'h0000_0084);
    chk("wrap_w20", 64'(rget(30'h20)), 64'hCAFE_0001);
    chk("wrap_w21", 64'(rget(30'h21)), 64'hCAFE_0002);

    // Forward overlap replicates the leading word
    ram[0] = 32'hAAAA_AAAA; ram[1] = 32'hBBBB_BBBB; ram[2] = 32'hCCCC_CCCC; ram[3] = 32'hDDDD_DDDD;
    model_copy(32'h0, 32'h4, 3);
    run_xfer(32'h0, 32'h4, 8'd3, 0, 0, 0);
    verify("overlap", 3, 7, 6, 3);
    for (int i = 0; i < 4; i++) chk($sformatf("overlap_w%0d", i), 64'(rget(30'(i))), 64'hAAAA_AAAA);

    // Randomized transfers against the reference model
    for (int t = 0; t < 12; t++) begin
      s = {$urandom_range(0, 60), 2'($urandom)};
      d = {$urandom_range(0, 60), 2'($urandom)};
      if (t % 4 == 3) s = $urandom;
      n = $urandom_range(0, 24);
      model_copy(s, d, n);
      run_xfer(s, d, 8'(n), 0, 0, 0);
      verify($sformatf("rnd%0d", t), n, 2 * n + 1, 2 * n, n);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
